// File: rtl/sr_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sr_trace_pkg
// Brief   : Shared state encoding and entry-width helpers for the trace buffer.
// Revision: 1.0
// ============================================================================
package sr_trace_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_TMO  = 2'd2
    } trace_state_t;

    localparam int INSTR_W = 32;

    function automatic int trace_entry_w(input int ts_w, input int pc_w);
        return ts_w + pc_w + INSTR_W;
    endfunction

    localparam int TRACE_ENTRY_W = trace_entry_w(32, 32);

endpackage
`default_nettype wire

// File: rtl/sr_trace_ram.sv
`default_nettype none
// ============================================================================
// Module  : sr_trace_ram
// Brief   : Simple dual-port entry store, synchronous write, registered read.
// Revision: 1.0
// ============================================================================
module sr_trace_ram
    import sr_trace_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = TRACE_ENTRY_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read-before-write on an address collision returns the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sr_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module  : sr_trace_buffer
// Brief   : Retirement trace FIFO with halt detection and fetch watchdog.
// Revision: 1.0
// ============================================================================
module sr_trace_buffer
    import sr_trace_pkg::*;
#(
    parameter int          PC_W       = 32,
    parameter int          TS_W       = 32,
    parameter int          DEPTH      = 16,
    parameter int          CIRCULAR   = 1,
    parameter logic [31:0] HALT_INSTR = 32'h63,
    parameter int unsigned TIMEOUT    = 120
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     im_drdy,
    input  logic [PC_W-1:0]          pc,
    input  logic [31:0]              instr,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [TS_W-1:0]          rd_ts,
    output logic [PC_W-1:0]          rd_pc,
    output logic [31:0]              rd_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic [TS_W-1:0]          retired,
    output logic                     halted,
    output logic                     timed_out,
    output logic                     overflow
);

    localparam int              c_AW      = $clog2(DEPTH);
    localparam int              c_CW      = c_AW + 1;
    localparam int              c_EW      = trace_entry_w(TS_W, PC_W);
    localparam int              c_IW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(DEPTH);
    localparam logic [c_IW-1:0] c_TMO     = c_IW'(TIMEOUT);
    localparam bit              c_CIRC    = (CIRCULAR != 0);
    localparam bit              c_WDOG_EN = (TIMEOUT != 0);

    trace_state_t    r_state, w_state_nxt;
    logic [TS_W-1:0] r_cycle;
    logic [TS_W-1:0] r_retired;
    logic [c_IW-1:0] r_idle, w_idle_nxt;
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_overflow;
    logic            r_rd_valid;

    logic            w_cap, w_rd, w_full, w_wr, w_loss, w_rd_adv, w_inc, w_dec;
    logic [c_EW-1:0] w_wdata, w_rdata;

    assign w_full   = (r_count == c_DEPTH);
    assign w_cap    = im_drdy && !clr && (r_state == ST_RUN);
    assign w_rd     = rd_en && !clr && (r_count != '0);
    assign w_wr     = w_cap && (!w_full || w_rd || c_CIRC);
    // A capture into a full buffer with no concurrent pop loses an entry.
    assign w_loss   = w_cap && w_full && !w_rd;
    assign w_rd_adv = w_rd || (w_loss && c_CIRC);
    assign w_inc    = w_wr && !w_rd && !w_full;
    assign w_dec    = w_rd && !w_wr;
    assign w_wdata  = {r_cycle, pc, instr};

    always_comb begin
        w_idle_nxt = r_idle;
        if (r_state == ST_RUN) begin
            if (im_drdy) begin
                w_idle_nxt = '0;
            end else if (r_idle != c_TMO) begin
                w_idle_nxt = r_idle + c_IW'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = ST_RUN;
        end else if (r_state == ST_RUN) begin
            if (w_cap && (instr == HALT_INSTR)) begin
                w_state_nxt = ST_HALT;
            end else if (c_WDOG_EN && (w_idle_nxt == c_TMO)) begin
                w_state_nxt = ST_TMO;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle    <= '0;
            r_retired  <= '0;
            r_idle     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_rd_valid <= 1'b0;
        end else if (clr) begin
            r_cycle    <= '0;
            r_retired  <= '0;
            r_idle     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_cycle    <= r_cycle + TS_W'(1);
            r_idle     <= w_idle_nxt;
            r_rd_valid <= w_rd;
            if (w_cap) begin
                r_retired <= r_retired + TS_W'(1);
            end
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_inc) begin
                r_count <= r_count + c_CW'(1);
            end else if (w_dec) begin
                r_count <= r_count - c_CW'(1);
            end
            if (w_loss) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sr_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (c_EW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_re    (w_rd),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign rd_valid  = r_rd_valid;
    assign rd_ts     = w_rdata[c_EW-1 -: TS_W];
    assign rd_pc     = w_rdata[PC_W+31 -: PC_W];
    assign rd_instr  = w_rdata[31:0];
    assign count     = r_count;
    assign retired   = r_retired;
    assign halted    = (r_state == ST_HALT);
    assign timed_out = (r_state == ST_TMO);
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sr_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_sr_trace_buffer
// Brief   : Directed bench; circular and drop-mode instances share stimulus.
// Revision: 1.0
// ============================================================================
module tb_sr_trace_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        im_drdy = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;

    logic        rdv_c, hlt_c, tmo_c, ovf_c;
    logic [31:0] ts_c, pc_c, ins_c, ret_c;
    logic [4:0]  cnt_c;
    logic        rdv_d, hlt_d, tmo_d, ovf_d;
    logic [31:0] ts_d, pc_d, ins_d, ret_d;
    logic [4:0]  cnt_d;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] t0, t1, t2;

    always #5 clk = ~clk;

    sr_trace_buffer #(.CIRCULAR(1)) u_dut_c (
        .clk(clk), .rst(rst), .clr(clr), .im_drdy(im_drdy), .pc(pc), .instr(instr),
        .rd_en(rd_en), .rd_valid(rdv_c), .rd_ts(ts_c), .rd_pc(pc_c), .rd_instr(ins_c),
        .count(cnt_c), .retired(ret_c), .halted(hlt_c), .timed_out(tmo_c), .overflow(ovf_c)
    );

    sr_trace_buffer #(.CIRCULAR(0)) u_dut_d (
        .clk(clk), .rst(rst), .clr(clr), .im_drdy(im_drdy), .pc(pc), .instr(instr),
        .rd_en(rd_en), .rd_valid(rdv_d), .rd_ts(ts_d), .rd_pc(pc_d), .rd_instr(ins_d),
        .count(cnt_d), .retired(ret_d), .halted(hlt_d), .timed_out(tmo_d), .overflow(ovf_d)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [31:0] p, input logic [31:0] i);
        im_drdy = 1'b1;
        pc      = p;
        instr   = i;
        step();
        im_drdy = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        step();
        step();
        check("rst_cnt", cnt_c, 0);
        check("rst_ret", ret_c, 0);
        check("rst_rdv", rdv_c, 0);
        check("rst_flags", {hlt_c, tmo_c, ovf_c}, 0);
        rst = 1'b0;
        step();

        // Basic capture and drain
        cap(32'h0, 32'h00500513);
        cap(32'h4, 32'h00A00593);
        cap(32'h8, 32'h00B50633);
        check("t1_cnt", cnt_c, 3);
        check("t1_ret", ret_c, 3);
        pop();
        check("t1_rdv0", rdv_c, 1);
        check("t1_pc0", pc_c, 32'h0);
        check("t1_ins0", ins_c, 32'h00500513);
        t0 = ts_c;
        pop();
        check("t1_pc1", pc_c, 32'h4);
        t1 = ts_c;
        pop();
        check("t1_pc2", pc_c, 32'h8);
        check("t1_ins2", ins_c, 32'h00B50633);
        t2 = ts_c;
        check("t1_ts01", t1 - t0, 1);
        check("t1_ts12", t2 - t1, 1);
        step();
        check("t1_rdv_end", rdv_c, 0);
        check("t1_cnt_end", cnt_c, 0);
        pop();
        check("t1_empty_rd", rdv_c, 0);

        // 20 captures into a 16-deep buffer, both overflow policies
        do_clr();
        for (int i = 0; i < 20; i++) cap(32'(4 * i), 32'h13);
        check("t2_cnt_c", cnt_c, 16);
        check("t2_ovf_c", ovf_c, 1);
        check("t2_ret_c", ret_c, 20);
        check("t3_cnt_d", cnt_d, 16);
        check("t3_ovf_d", ovf_d, 1);
        check("t3_ret_d", ret_d, 20);
        pop();
        check("t2_first_c", pc_c, 32'h10);
        check("t3_first_d", pc_d, 32'h0);
        for (int i = 0; i < 15; i++) pop();
        check("t2_last_c", pc_c, 32'h4C);
        check("t3_last_d", pc_d, 32'h3C);
        check("t2_cnt0_c", cnt_c, 0);
        check("t3_cnt0_d", cnt_d, 0);

        // Full buffer with concurrent pop and capture
        do_clr();
        for (int i = 0; i < 16; i++) cap(32'(4 * i), 32'h13);
        check("t6_full_c", cnt_c, 16);
        check("t6_ovf0_c", ovf_c, 0);
        im_drdy = 1'b1;
        pc      = 32'h100;
        rd_en   = 1'b1;
        step();
        im_drdy = 1'b0;
        rd_en   = 1'b0;
        check("t6_rdv_c", rdv_c, 1);
        check("t6_pc_c", pc_c, 32'h0);
        check("t6_cnt_c", cnt_c, 16);
        check("t6_ovf_c", ovf_c, 0);
        check("t6_pc_d", pc_d, 32'h0);
        check("t6_cnt_d", cnt_d, 16);
        check("t6_ovf_d", ovf_d, 0);
        for (int i = 0; i < 16; i++) pop();
        check("t6_last_c", pc_c, 32'h100);
        check("t6_last_d", pc_d, 32'h100);

        // Halt opcode
        do_clr();
        cap(32'h1C, 32'h13);
        cap(32'h20, 32'h13);
        cap(32'h24, 32'h63);
        check("t4_halt", hlt_c, 1);
        check("t4_ret", ret_c, 3);
        cap(32'h28, 32'h13);
        cap(32'h2C, 32'h13);
        check("t4_ret_frozen", ret_c, 3);
        check("t4_cnt", cnt_c, 3);
        for (int i = 0; i < 3; i++) pop();
        check("t4_last_pc", pc_c, 32'h24);
        check("t4_last_ins", ins_c, 32'h63);
        check("t4_halt_hold", hlt_c, 1);

        // Watchdog
        do_clr();
        check("t5_run", {hlt_c, tmo_c}, 0);
        cap(32'h40, 32'h13);
        repeat (119) step();
        check("t5_tmo_119", tmo_c, 0);
        step();
        check("t5_tmo_120_c", tmo_c, 1);
        check("t5_tmo_120_d", tmo_d, 1);
        clr   = 1'b1;
        rd_en = 1'b1;
        step();
        clr   = 1'b0;
        rd_en = 1'b0;
        check("t5_clr_rdv", rdv_c, 0);
        check("t5_clr_cnt", cnt_c, 0);
        check("t5_clr_tmo", tmo_c, 0);
        cap(32'h44, 32'h13);
        pop();
        check("t5_ts0", ts_c, 0);
        check("t5_pc", pc_c, 32'h44);

        // Asynchronous reset in the middle of traffic
        cap(32'h80, 32'h13);
        cap(32'h84, 32'h13);
        im_drdy = 1'b1;
        pc      = 32'h88;
        rd_en   = 1'b1;
        step();
        check("t7_pre_pc", pc_c, 32'h80);
        #2 rst = 1'b1;
        #1;
        check("t7_rdv", rdv_c, 0);
        check("t7_rd", {ts_c, pc_c}, 0);
        check("t7_ins", ins_c, 0);
        check("t7_cnt", cnt_c, 0);
        check("t7_ret", ret_c, 0);
        check("t7_flags", {hlt_c, tmo_c, ovf_c}, 0);
        im_drdy = 1'b0;
        rd_en   = 1'b0;
        step();
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
